// File: rtl/light_monitor.sv
// light_monitor: passive checker for a two-direction traffic-light controller.
// Registers the A/B light codes once, then tracks the G/R -> Y/R -> R/G -> R/Y
// phase ring on that sample, flagging illegal codes, conflicting greens,
// out-of-order transitions and wrong yellow durations. Never drives the lights.
module light_monitor #(
  parameter int unsigned YELLOW_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [1:0]       i_LA,
  input  logic [1:0]       i_LB,
  input  logic             i_clr,
  output logic             o_err,
  output logic [3:0]       o_err_flags,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [2:0]       o_phase
);

  localparam logic [1:0] LC_GREEN  = 2'b00;
  localparam logic [1:0] LC_RED    = 2'b01;
  localparam logic [1:0] LC_YELLOW = 2'b10;
  localparam logic [1:0] LC_BAD    = 2'b11;

  // Yellow counter must hold YELLOW_CYCLES+1 (the "too long" saturation point).
  localparam int unsigned     YC_W    = $clog2(YELLOW_CYCLES + 2);
  localparam logic [YC_W-1:0] YC_ZERO = YC_W'(0);
  localparam logic [YC_W-1:0] YC_ONE  = YC_W'(1);
  localparam logic [YC_W-1:0] YC_REQ  = YC_W'(YELLOW_CYCLES);
  localparam logic [YC_W-1:0] YC_MAX  = YC_W'(YELLOW_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    PH_INIT = 3'd0,
    PH_P0   = 3'd1,
    PH_P1   = 3'd2,
    PH_P2   = 3'd3,
    PH_P3   = 3'd4
  } phase_e;

  function automatic phase_e succ_of(input phase_e p);
    case (p)
      PH_P0:   succ_of = PH_P1;
      PH_P1:   succ_of = PH_P2;
      PH_P2:   succ_of = PH_P3;
      PH_P3:   succ_of = PH_P0;
      default: succ_of = PH_INIT;
    endcase
  endfunction

  function automatic logic is_yellow(input phase_e p);
    return (p == PH_P1) || (p == PH_P3);
  endfunction

  logic [1:0]       la_q, lb_q;
  phase_e           phase_q, phase_d;
  logic [YC_W-1:0]  ycnt_q, ycnt_d;
  logic             ychk_q, ychk_d;     // current yellow was entered in order
  logic             err_q, err_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [CNT_W-1:0] ccnt_q, ccnt_d;

  logic             illegal_s, conflict_s, legal_s;
  phase_e           pair_s;
  logic             bad_s, ylen_s, wrap_s;
  logic [3:0]       new_err_s;
  logic [CNT_W-1:0] ecnt_base_s, ccnt_base_s;

  // Capture the raw light codes; every check works on this registered sample.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      la_q <= LC_RED;
      lb_q <= LC_RED;
    end else begin
      la_q <= i_LA;
      lb_q <= i_LB;
    end
  end

  // Classify the registered sample into code errors and a legal phase pair.
  always_comb begin
    illegal_s  = (la_q == LC_BAD) || (lb_q == LC_BAD);
    conflict_s = (la_q != LC_RED) && (lb_q != LC_RED);
    legal_s    = 1'b1;
    pair_s     = PH_INIT;
    case ({la_q, lb_q})
      {LC_GREEN, LC_RED}:    pair_s = PH_P0;
      {LC_YELLOW, LC_RED}:   pair_s = PH_P1;
      {LC_RED, LC_GREEN}:    pair_s = PH_P2;
      {LC_RED, LC_YELLOW}:   pair_s = PH_P3;
      default: begin
        pair_s  = PH_INIT;
        legal_s = 1'b0;
      end
    endcase
  end

  // Tracker state register: phase, yellow length and short-check enable.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      phase_q <= PH_INIT;
      ycnt_q  <= YC_ZERO;
      ychk_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ycnt_q  <= ycnt_d;
      ychk_q  <= ychk_d;
    end
  end

  // Tracker next state plus the sequencing checks it implies.
  always_comb begin
    phase_d = phase_q;
    ycnt_d  = ycnt_q;
    ychk_d  = ychk_q;
    bad_s   = 1'b0;
    ylen_s  = 1'b0;
    wrap_s  = 1'b0;
    if (phase_q == PH_INIT) begin
      // Lock onto the first legal pair; a yellow found here is not short-checked.
      if (legal_s) begin
        phase_d = pair_s;
        ycnt_d  = YC_ONE;
        ychk_d  = 1'b0;
      end else begin
        phase_d = PH_INIT;
        ycnt_d  = YC_ZERO;
        ychk_d  = 1'b0;
      end
    end else if (legal_s && (pair_s == phase_q)) begin
      // Holding: yellow counts up and flags once on reaching YELLOW_CYCLES+1.
      if (is_yellow(phase_q)) begin
        if (ycnt_q < YC_MAX) begin
          ycnt_d = ycnt_q + YC_ONE;
        end else begin
          ycnt_d = ycnt_q;
        end
        ylen_s = (ycnt_q == YC_REQ);
      end else begin
        ycnt_d = ycnt_q;
      end
    end else begin
      // Leaving the phase: a yellow entered in order must have run long enough.
      ylen_s = is_yellow(phase_q) && ychk_q && (ycnt_q < YC_REQ);
      if (legal_s && (pair_s == succ_of(phase_q))) begin
        phase_d = pair_s;
        ycnt_d  = YC_ONE;
        ychk_d  = 1'b1;
        wrap_s  = (phase_q == PH_P3);
      end else if (legal_s) begin
        bad_s   = 1'b1;
        phase_d = pair_s;
        ycnt_d  = YC_ONE;
        ychk_d  = 1'b0;
      end else begin
        bad_s   = 1'b1;
        phase_d = PH_INIT;
        ycnt_d  = YC_ZERO;
        ychk_d  = 1'b0;
      end
    end
  end

  // Output next state: sticky flags, saturating error count, wrapping cycle count.
  always_comb begin
    new_err_s   = {ylen_s, bad_s, conflict_s, illegal_s};
    err_d       = |new_err_s;
    flags_d     = (i_clr ? 4'b0000 : flags_q) | new_err_s;
    ecnt_base_s = i_clr ? CNT_ZERO : ecnt_q;
    ccnt_base_s = i_clr ? CNT_ZERO : ccnt_q;
    if (err_d && (ecnt_base_s != CNT_MAX)) begin
      ecnt_d = ecnt_base_s + CNT_ONE;
    end else begin
      ecnt_d = ecnt_base_s;
    end
    if (wrap_s) begin
      ccnt_d = ccnt_base_s + CNT_ONE;
    end else begin
      ccnt_d = ccnt_base_s;
    end
  end

  // Output registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      err_q   <= 1'b0;
      flags_q <= 4'b0000;
      ecnt_q  <= CNT_ZERO;
      ccnt_q  <= CNT_ZERO;
    end else begin
      err_q   <= err_d;
      flags_q <= flags_d;
      ecnt_q  <= ecnt_d;
      ccnt_q  <= ccnt_d;
    end
  end

  assign o_err       = err_q;
  assign o_err_flags = flags_q;
  assign o_err_cnt   = ecnt_q;
  assign o_cycle_cnt = ccnt_q;
  assign o_phase     = phase_q;

endmodule

// File: tb/tb_light_monitor.sv
// Testbench for light_monitor: three instances (YELLOW_CYCLES 1 and 2 with
// 16-bit counters, and YELLOW_CYCLES 1 with 2-bit counters) share the stimulus.
// Each row pushes its expected outputs; they are popped two edges later.
module tb_light_monitor;

  localparam logic [1:0] G = 2'b00;
  localparam logic [1:0] R = 2'b01;
  localparam logic [1:0] Y = 2'b10;
  localparam logic [1:0] X = 2'b11;

  typedef struct packed {
    logic        err;
    logic [3:0]  flags;
    logic [15:0] ecnt;
    logic [15:0] ccnt;
    logic [2:0]  ph;
  } obs_t;

  typedef struct packed {
    logic [1:0] la;
    logic [1:0] lb;
    logic       clr;
    obs_t       exp;
  } row_t;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       clr  = 1'b0;
  logic [1:0] la   = R;
  logic [1:0] lb   = R;

  logic        a_err, b_err, c_err;
  logic [3:0]  a_flags, b_flags, c_flags;
  logic [15:0] a_ecnt, a_ccnt, b_ecnt, b_ccnt;
  logic [1:0]  c_ecnt, c_ccnt;
  logic [2:0]  a_ph, b_ph, c_ph;
  obs_t        obs0, obs1, obs2;

  row_t stim[$];
  obs_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  light_monitor #(.YELLOW_CYCLES(1), .CNT_W(16)) dut_y1 (
    .i_clk(clk), .i_rstn(rstn), .i_LA(la), .i_LB(lb), .i_clr(clr),
    .o_err(a_err), .o_err_flags(a_flags), .o_err_cnt(a_ecnt),
    .o_cycle_cnt(a_ccnt), .o_phase(a_ph));

  light_monitor #(.YELLOW_CYCLES(2), .CNT_W(16)) dut_y2 (
    .i_clk(clk), .i_rstn(rstn), .i_LA(la), .i_LB(lb), .i_clr(clr),
    .o_err(b_err), .o_err_flags(b_flags), .o_err_cnt(b_ecnt),
    .o_cycle_cnt(b_ccnt), .o_phase(b_ph));

  light_monitor #(.YELLOW_CYCLES(1), .CNT_W(2)) dut_c2 (
    .i_clk(clk), .i_rstn(rstn), .i_LA(la), .i_LB(lb), .i_clr(clr),
    .o_err(c_err), .o_err_flags(c_flags), .o_err_cnt(c_ecnt),
    .o_cycle_cnt(c_ccnt), .o_phase(c_ph));

  assign obs0 = {a_err, a_flags, a_ecnt, a_ccnt, a_ph};
  assign obs1 = {b_err, b_flags, b_ecnt, b_ccnt, b_ph};
  assign obs2 = {c_err, c_flags, 14'd0, c_ecnt, 14'd0, c_ccnt, c_ph};

  function automatic obs_t pick(input int d);
    case (d)
      0:       return obs0;
      1:       return obs1;
      default: return obs2;
    endcase
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("err=%b flags=%b ecnt=%0d ccnt=%0d phase=%0d",
                     o.err, o.flags, o.ecnt, o.ccnt, o.ph);
  endfunction

  function automatic void add(input logic [1:0] a, input logic [1:0] b, input logic c,
                              input logic e, input logic [3:0] f, input int ec,
                              input int cc, input int ph);
    row_t r;
    r.la = a; r.lb = b; r.clr = c;
    r.exp.err = e; r.exp.flags = f;
    r.exp.ecnt = 16'(ec); r.exp.ccnt = 16'(cc); r.exp.ph = 3'(ph);
    stim.push_back(r);
  endfunction

  task automatic do_reset();
    rstn = 1'b0; la = R; lb = R; clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got;
    rstn = 1'b0; la = R; lb = R; clr = 1'b0;
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      got = pick(d);
      n_cmp++;
      if (got !== 40'd0) begin
        n_bad++;
        $display("FAIL reset dut%0d: got %s, expected all zero", d, fmt(got));
      end
    end
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    got = pick(0);
    n_cmp++;
    if (got !== 40'd0) begin
      n_bad++;
      $display("FAIL reset_idle: got %s, expected all zero", fmt(got));
    end
  endtask

  task automatic test_sequence();
    obs_t got, want;
    stim.delete();
    do_reset();
    for (int i = 0; i < 3; i++) add(G, R, 1'b0, 1'b0, 4'b0000, 0, 0, 1);
    add(Y, R, 1'b0, 1'b0, 4'b0000, 0, 0, 2);
    add(R, G, 1'b0, 1'b0, 4'b0000, 0, 0, 3);
    add(R, G, 1'b0, 1'b0, 4'b0000, 0, 0, 3);
    add(R, Y, 1'b0, 1'b0, 4'b0000, 0, 0, 4);
    add(G, R, 1'b0, 1'b0, 4'b0000, 0, 1, 1);
    for (int k = 0; k < stim.size() + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        got = obs0; want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL sequence row %0d: got %s, expected %s", k - 2, fmt(got), fmt(want));
        end
      end
      if (k < stim.size()) begin
        la = stim[k].la; lb = stim[k].lb; sb.push_back(stim[k].exp);
      end
      if (k >= 1 && k <= stim.size()) clr = stim[k-1].clr;
      else clr = 1'b0;
    end
  endtask

  task automatic test_conflict();
    obs_t got, want;
    stim.delete();
    do_reset();
    add(G, R, 1'b0, 1'b0, 4'b0000, 0, 0, 1);
    add(G, R, 1'b0, 1'b0, 4'b0000, 0, 0, 1);
    add(G, G, 1'b0, 1'b1, 4'b0110, 1, 0, 0);
    add(R, G, 1'b0, 1'b0, 4'b0110, 1, 0, 3);
    add(R, G, 1'b0, 1'b0, 4'b0110, 1, 0, 3);
    add(Y, Y, 1'b0, 1'b1, 4'b0110, 2, 0, 0);
    add(Y, Y, 1'b0, 1'b1, 4'b0110, 3, 0, 0);
    add(R, R, 1'b0, 1'b0, 4'b0110, 3, 0, 0);
    for (int k = 0; k < stim.size() + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        got = obs0; want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL conflict row %0d: got %s, expected %s", k - 2, fmt(got), fmt(want));
        end
      end
      if (k < stim.size()) begin
        la = stim[k].la; lb = stim[k].lb; sb.push_back(stim[k].exp);
      end
      if (k >= 1 && k <= stim.size()) clr = stim[k-1].clr;
      else clr = 1'b0;
    end
  endtask

  task automatic test_illegal();
    obs_t got, want;
    stim.delete();
    do_reset();
    add(X, G, 1'b0, 1'b1, 4'b0011, 1, 0, 0);
    add(R, X, 1'b0, 1'b1, 4'b0011, 2, 0, 0);
    add(Y, R, 1'b0, 1'b0, 4'b0011, 2, 0, 2);
    add(Y, R, 1'b0, 1'b1, 4'b1011, 3, 0, 2);
    add(Y, R, 1'b0, 1'b0, 4'b1011, 3, 0, 2);
    for (int k = 0; k < stim.size() + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        got = obs0; want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL illegal row %0d: got %s, expected %s", k - 2, fmt(got), fmt(want));
        end
      end
      if (k < stim.size()) begin
        la = stim[k].la; lb = stim[k].lb; sb.push_back(stim[k].exp);
      end
      if (k >= 1 && k <= stim.size()) clr = stim[k-1].clr;
      else clr = 1'b0;
    end
  endtask

  task automatic test_yellow_len();
    obs_t got, want;
    stim.delete();
    do_reset();
    add(G, R, 1'b0, 1'b0, 4'b0000, 0, 0, 1);
    add(Y, R, 1'b0, 1'b0, 4'b0000, 0, 0, 2);
    add(R, G, 1'b0, 1'b1, 4'b1000, 1, 0, 3);
    add(R, Y, 1'b0, 1'b0, 4'b1000, 1, 0, 4);
    add(R, Y, 1'b0, 1'b0, 4'b1000, 1, 0, 4);
    add(R, Y, 1'b0, 1'b1, 4'b1000, 2, 0, 4);
    add(R, Y, 1'b0, 1'b0, 4'b1000, 2, 0, 4);
    add(G, R, 1'b0, 1'b0, 4'b1000, 2, 1, 1);
    for (int k = 0; k < stim.size() + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        got = obs1; want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL yellow_len row %0d: got %s, expected %s", k - 2, fmt(got), fmt(want));
        end
      end
      if (k < stim.size()) begin
        la = stim[k].la; lb = stim[k].lb; sb.push_back(stim[k].exp);
      end
      if (k >= 1 && k <= stim.size()) clr = stim[k-1].clr;
      else clr = 1'b0;
    end
  endtask

  task automatic test_resync_clr();
    obs_t got, want;
    stim.delete();
    do_reset();
    add(G, R, 1'b0, 1'b0, 4'b0000, 0, 0, 1);
    add(R, G, 1'b0, 1'b1, 4'b0100, 1, 0, 3);
    add(R, G, 1'b0, 1'b0, 4'b0100, 1, 0, 3);
    add(R, R, 1'b0, 1'b1, 4'b0100, 2, 0, 0);
    add(G, Y, 1'b1, 1'b1, 4'b0010, 1, 0, 0);
    add(R, R, 1'b0, 1'b0, 4'b0010, 1, 0, 0);
    for (int c = 0; c < 2; c++) begin
      add(G, R, 1'b0, 1'b0, 4'b0010, 1, c, 1);
      add(Y, R, 1'b0, 1'b0, 4'b0010, 1, c, 2);
      add(R, G, 1'b0, 1'b0, 4'b0010, 1, c, 3);
      add(R, Y, 1'b0, 1'b0, 4'b0010, 1, c, 4);
    end
    add(G, R, 1'b1, 1'b0, 4'b0000, 0, 1, 1);
    add(G, R, 1'b0, 1'b0, 4'b0000, 0, 1, 1);
    for (int k = 0; k < stim.size() + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        got = obs0; want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL resync_clr row %0d: got %s, expected %s", k - 2, fmt(got), fmt(want));
        end
      end
      if (k < stim.size()) begin
        la = stim[k].la; lb = stim[k].lb; sb.push_back(stim[k].exp);
      end
      if (k >= 1 && k <= stim.size()) clr = stim[k-1].clr;
      else clr = 1'b0;
    end
  endtask

  task automatic test_saturate_wrap();
    obs_t got, want;
    stim.delete();
    do_reset();
    add(G, G, 1'b0, 1'b1, 4'b0010, 1, 0, 0);
    add(G, G, 1'b0, 1'b1, 4'b0010, 2, 0, 0);
    for (int i = 0; i < 3; i++) add(G, G, 1'b0, 1'b1, 4'b0010, 3, 0, 0);
    add(G, R, 1'b0, 1'b0, 4'b0010, 3, 0, 1);
    for (int c = 1; c <= 4; c++) begin
      add(Y, R, 1'b0, 1'b0, 4'b0010, 3, c - 1, 2);
      add(R, G, 1'b0, 1'b0, 4'b0010, 3, c - 1, 3);
      add(R, Y, 1'b0, 1'b0, 4'b0010, 3, c - 1, 4);
      add(G, R, 1'b0, 1'b0, 4'b0010, 3, c % 4, 1);
    end
    for (int k = 0; k < stim.size() + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        got = obs2; want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL saturate_wrap row %0d: got %s, expected %s", k - 2, fmt(got), fmt(want));
        end
      end
      if (k < stim.size()) begin
        la = stim[k].la; lb = stim[k].lb; sb.push_back(stim[k].exp);
      end
      if (k >= 1 && k <= stim.size()) clr = stim[k-1].clr;
      else clr = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, want;
    stim.delete();
    do_reset();
    add(G, R, 1'b0, 1'b0, 4'b0000, 0, 0, 1);
    add(Y, R, 1'b0, 1'b0, 4'b0000, 0, 0, 2);
    add(Y, R, 1'b0, 1'b0, 4'b0000, 0, 0, 2);
    for (int k = 0; k < stim.size() + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        got = obs1; want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL reset_mid pre row %0d: got %s, expected %s", k - 2, fmt(got), fmt(want));
        end
      end
      if (k < stim.size()) begin
        la = stim[k].la; lb = stim[k].lb; sb.push_back(stim[k].exp);
      end
      if (k >= 1 && k <= stim.size()) clr = stim[k-1].clr;
      else clr = 1'b0;
    end
    // Asynchronous reset in the middle of the yellow phase.
    #2 rstn = 1'b0;
    #1;
    got = obs1; n_cmp++;
    if (got !== 40'd0) begin
      n_bad++;
      $display("FAIL reset_mid async: got %s, expected all zero", fmt(got));
    end
    la = R; lb = R;
    @(negedge clk);
    rstn = 1'b1;
    stim.delete();
    add(Y, R, 1'b0, 1'b0, 4'b0000, 0, 0, 2);
    add(R, G, 1'b0, 1'b0, 4'b0000, 0, 0, 3);
    add(R, G, 1'b0, 1'b0, 4'b0000, 0, 0, 3);
    for (int k = 0; k < stim.size() + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        got = obs1; want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL reset_mid post row %0d: got %s, expected %s", k - 2, fmt(got), fmt(want));
        end
      end
      if (k < stim.size()) begin
        la = stim[k].la; lb = stim[k].lb; sb.push_back(stim[k].exp);
      end
      if (k >= 1 && k <= stim.size()) clr = stim[k-1].clr;
      else clr = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_conflict();
    test_illegal();
    test_yellow_len();
    test_resync_clr();
    test_saturate_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
